// File: rtl/vga_ctrl_pkg.sv
// rtl/vga_ctrl_pkg.sv - shared constants, state encoding and clamp helper for the VGA position arbiter
package vga_ctrl_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int POS_W    = 10;
    localparam int COLOR_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        COMMIT  = 2'd2
    } arb_state_t;

    function automatic logic [POS_W-1:0] clamp_pos(
        input logic [POS_W-1:0] v,
        input logic [POS_W-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set search starting at the rr pointer
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            // rr < NREQ, so a single wrap keeps idx in range
            idx = int'(rr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!valid && req[idx]) begin
                grant = IDX_W'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pos_arbiter.sv
// rtl/vga_pos_arbiter.sv - round-robin arbiter committing one object position/colour update per frame at vsync
module vga_pos_arbiter
    import vga_ctrl_pkg::*;
#(
    parameter int                 NREQ       = 2,
    parameter int                 OBJ_W      = 16,
    parameter int                 OBJ_H      = 16,
    parameter logic [POS_W-1:0]   X_INIT     = 10'd312,
    parameter logic [POS_W-1:0]   Y_INIT     = 10'd232,
    parameter logic [COLOR_W-1:0] COLOR_INIT = 3'b111
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    vsync,
    input  logic [NREQ-1:0]         req,
    input  logic [POS_W*NREQ-1:0]   req_x,
    input  logic [POS_W*NREQ-1:0]   req_y,
    input  logic [COLOR_W*NREQ-1:0] req_color,
    output logic [NREQ-1:0]         ack,
    output logic [POS_W-1:0]        X_POS,
    output logic [POS_W-1:0]        Y_POS,
    output logic [COLOR_W-1:0]      color,
    output logic                    pending
);

    localparam int               IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - OBJ_W);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - OBJ_H);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NREQ - 1);

    logic [POS_W-1:0]   rx [NREQ];
    logic [POS_W-1:0]   ry [NREQ];
    logic [COLOR_W-1:0] rc [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign rx[i] = req_x[POS_W*i +: POS_W];
        assign ry[i] = req_y[POS_W*i +: POS_W];
        assign rc[i] = req_color[COLOR_W*i +: COLOR_W];
    end

    // vsync comes from the pixel-clock domain
    logic vs_meta;
    logic vs_sync;
    logic vs_prev;
    logic vs_fall;

    assign vs_fall = vs_prev & ~vs_sync;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] g_q;
    logic [POS_W-1:0] x_q;
    logic [POS_W-1:0] y_q;
    logic [COLOR_W-1:0] c_q;

    logic [IDX_W-1:0] pick_g;
    logic             pick_valid;
    logic             latch_en;
    logic             commit_en;
    logic [NREQ-1:0]  ack_next;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .rr    (rr_q),
        .grant (pick_g),
        .valid (pick_valid)
    );

    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        commit_en  = 1'b0;
        ack_next   = '0;
        case (state)
            IDLE: begin
                // a vs_fall seen here is deliberately ignored: the commit waits a full frame
                if (pick_valid) begin
                    latch_en   = 1'b1;
                    state_next = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_next    = COMMIT;
                    ack_next[g_q] = 1'b1;
                end
            end
            COMMIT: begin
                commit_en  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
            state   <= IDLE;
            rr_q    <= '0;
            g_q     <= '0;
            x_q     <= X_INIT;
            y_q     <= Y_INIT;
            c_q     <= COLOR_INIT;
            ack     <= '0;
            X_POS   <= X_INIT;
            Y_POS   <= Y_INIT;
            color   <= COLOR_INIT;
        end else begin
            vs_meta <= vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
            state   <= state_next;
            ack     <= ack_next;
            if (latch_en) begin
                g_q <= pick_g;
                x_q <= clamp_pos(rx[pick_g], X_MAX);
                y_q <= clamp_pos(ry[pick_g], Y_MAX);
                c_q <= rc[pick_g];
            end
            if (commit_en) begin
                X_POS <= x_q;
                Y_POS <= y_q;
                color <= c_q;
                rr_q  <= (g_q == LAST) ? '0 : g_q + 1'b1;
            end
        end
    end

    assign pending = (state != IDLE);

endmodule

// File: tb/tb_vga_pos_arbiter.sv
// tb/tb_vga_pos_arbiter.sv - scoreboard bench for vga_pos_arbiter
module tb_vga_pos_arbiter;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        vsync = 1'b1;
    logic [1:0]  req = '0;
    logic [19:0] req_x = '0;
    logic [19:0] req_y = '0;
    logic [5:0]  req_color = '0;
    logic [1:0]  ack;
    logic [9:0]  X_POS;
    logic [9:0]  Y_POS;
    logic [2:0]  color;
    logic        pending;

    vga_pos_arbiter #(.NREQ(2)) dut (
        .clk       (clk),
        .clr       (clr),
        .vsync     (vsync),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .ack       (ack),
        .X_POS     (X_POS),
        .Y_POS     (Y_POS),
        .color     (color),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int x;
        int y;
        int c;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   out_due = 1'b0;
    int   ack_count = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // outputs move on the edge that ends the ack cycle
    always @(negedge clk) begin
        if (out_due) begin
            check("x_pos", 32'(X_POS), 32'(cur.x));
            check("y_pos", 32'(Y_POS), 32'(cur.y));
            check("color", 32'(color), 32'(cur.c));
            out_due = 1'b0;
        end
        if (ack != 2'b00 && !$isunknown(ack)) begin
            ack_count++;
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                cur = sb.pop_front();
                check("ack_onehot", 32'(ack), 32'(1 << cur.idx));
                out_due = 1'b1;
            end
        end
    end

    task automatic set_req(input int i, input int x, input int y, input int c);
        req_x[i*10 +: 10]    = x[9:0];
        req_y[i*10 +: 10]    = y[9:0];
        req_color[i*3 +: 3]  = c[2:0];
    endtask

    task automatic push_exp(input int i, input int x, input int y, input int c);
        exp_t e;
        e.idx = i;
        e.x   = x;
        e.y   = y;
        e.c   = c;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 clr = 1'b1;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
    endtask

    // one frame: requester drops req on ack, optionally re-raises after one idle cycle
    task automatic run_frame(input bit reraise, input bit expect_ack, output int acks);
        int         a0;
        logic [1:0] hit;
        a0  = ack_count;
        hit = '0;
        @(posedge clk);
        #3 vsync = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                hit = ack;
                req = req & ~ack;
                break;
            end
        end
        if (expect_ack && hit == 2'b00) check("ack_timeout", 32'd0, 32'd1);
        if (reraise && hit != 2'b00) begin
            @(posedge clk);
            @(posedge clk);
            #1 req = req | hit;
        end
        @(posedge clk);
        #3 vsync = 1'b1;
        repeat (30) @(posedge clk);
        acks = ack_count - a0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int lat;
        int a0;

        // reset state
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("rst_x", 32'(X_POS), 32'd312);
        check("rst_y", 32'(Y_POS), 32'd232);
        check("rst_color", 32'(color), 32'd7);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);

        // single commit with latency bound
        @(posedge clk);
        #1 set_req(0, 100, 50, 4);
        req = 2'b01;
        push_exp(0, 100, 50, 4);
        check("pending_before", 32'(pending), 32'd0);
        @(posedge clk);
        #1 check("pending_rise", 32'(pending), 32'd1);
        a0 = ack_count;
        vsync = 1'b0;
        lat = 0;
        while (X_POS != 10'd100 && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        req = 2'b00;
        check("latency_le5", 32'(lat <= 5), 32'd1);
        repeat (3) @(posedge clk);
        #3 vsync = 1'b1;
        repeat (30) @(posedge clk);
        check("single_ack_count", 32'(ack_count - a0), 32'd1);
        check("pending_clear", 32'(pending), 32'd0);

        // round robin across three frames
        do_reset();
        set_req(0, 10, 20, 1);
        set_req(1, 30, 40, 2);
        req = 2'b11;
        push_exp(0, 10, 20, 1);
        push_exp(1, 30, 40, 2);
        push_exp(0, 10, 20, 1);
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b1, 1'b1, n);
            check("rr_one_per_frame", 32'(n), 32'd1);
        end
        req = 2'b00;
        do_reset();

        // clamp
        set_req(0, 700, 479, 5);
        req = 2'b01;
        push_exp(0, 624, 464, 5);
        run_frame(1'b0, 1'b1, n);
        check("clamp_ack_count", 32'(n), 32'd1);

        // late drop: data and req change after latch
        @(posedge clk);
        #1 set_req(1, 200, 100, 6);
        req = 2'b10;
        push_exp(1, 200, 100, 6);
        @(posedge clk);
        #1 check("late_pending", 32'(pending), 32'd1);
        req = 2'b00;
        set_req(1, 500, 300, 1);
        run_frame(1'b0, 1'b1, n);
        check("late_ack_count", 32'(n), 32'd1);

        // reset while waiting for vsync
        @(posedge clk);
        #1 set_req(0, 77, 88, 2);
        req = 2'b01;
        @(posedge clk);
        #1 check("mid_pending", 32'(pending), 32'd1);
        req = 2'b00;
        do_reset();
        @(negedge clk);
        check("mid_rst_x", 32'(X_POS), 32'd312);
        check("mid_rst_y", 32'(Y_POS), 32'd232);
        check("mid_rst_color", 32'(color), 32'd7);
        check("mid_rst_pending", 32'(pending), 32'd0);
        run_frame(1'b0, 1'b0, n);
        check("mid_no_ack", 32'(n), 32'd0);
        check("mid_hold_x", 32'(X_POS), 32'd312);
        check("mid_hold_color", 32'(color), 32'd7);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
